// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared FSM states, latency counter width and power-up image
// for the data memory responder.
package mem_resp_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam int CNT_W = 4;
   localparam int INIT_N = 6;
   // Element [i] holds word i of the power-up image.
   localparam logic [INIT_N-1:0][31:0] INIT_IMAGE = {32'd10, 32'd6, 32'd19, 32'd30, 32'd4, 32'd0};
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous DEPTH x 32 RAM with registered read data,
// preloaded with the power-up image; contents survive reset.
module mem_array
   import mem_resp_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW = 8
) (
   input  logic          clock,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH] = '{0: INIT_IMAGE[0], 1: INIT_IMAGE[1], 2: INIT_IMAGE[2],
                                3: INIT_IMAGE[3], 4: INIT_IMAGE[4], 5: INIT_IMAGE[5],
                                default: 32'd0};
   always_ff @(posedge clock) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else rdata <= mem[addr];
      end
   end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: serialised load/store responder with fixed access latency,
// one-cycle rvalid/wdone pulses and out-of-range err flag.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        rvalid,
   output logic [31:0] rdata,
   output logic        wdone,
   output logic        err
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   state_t state;
   logic [CNT_W-1:0] cnt;
   logic l_we, have, accept, commit, c_we, oor;
   logic [31:0] l_addr, l_wdata, c_addr, c_wdata, ram_rdata;
   assign ready = state != WAIT;
   assign accept = req && ready;
   // With single-cycle latency the commit happens on the accepting edge itself.
   assign commit = LATENCY == 1 ? accept : state == WAIT && cnt == '0;
   assign c_we = LATENCY == 1 ? we : l_we;
   assign c_addr = LATENCY == 1 ? addr : l_addr;
   assign c_wdata = LATENCY == 1 ? wdata : l_wdata;
   assign oor = c_addr >= 32'(DEPTH);
   // RAM read register has no reset, so gate it until a valid load lands.
   assign rdata = have ? ram_rdata : '0;
   mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clock(clock),
      .en(commit && !oor),
      .we(c_we),
      .addr(c_addr[AW-1:0]),
      .wdata(c_wdata),
      .rdata(ram_rdata)
   );
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         l_we <= 1'b0;
         l_addr <= '0;
         l_wdata <= '0;
         have <= 1'b0;
         rvalid <= 1'b0;
         wdone <= 1'b0;
         err <= 1'b0;
      end else begin
         rvalid <= commit && !c_we;
         wdone <= commit && c_we;
         err <= commit && oor;
         if (commit && !c_we) have <= !oor;
         if (accept) begin
            l_we <= we;
            l_addr <= addr;
            l_wdata <= wdata;
            cnt <= CNT_W'(LATENCY - 1);
            state <= LATENCY == 1 ? RESP : WAIT;
         end else if (state == WAIT) begin
            if (cnt == '0) state <= RESP;
            else cnt <= cnt - 1'b1;
         end else begin
            state <= IDLE;
         end
      end
   end
endmodule
